// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, assembled word and status out.
interface uart_rx_if #(
  parameter int NBYTES = 1
);
  logic                  rx_en;
  logic                  RxD;
  logic [NBYTES*8-1:0]   rx_data;
  logic                  rx_valid;
  logic                  rx_busy;
  logic                  frame_err;

  modport master (
    input  rx_en,
    input  RxD,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err
  );

  modport slave (
    output rx_en,
    output RxD,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RxD pin; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic q_r;

  // Metastability filter stages, preset to the line idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      q_r    <= 1'b1;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery, assembling NBYTES characters per word.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBYTES     = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  uart_rx_if.master rx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic                rxd_s;
  rx_state_e           state_r;
  logic [TW-1:0]       tick_cnt_r;
  logic [2:0]          bit_cnt_r;
  logic [BW-1:0]       byte_cnt_r;
  logic [7:0]          shift_r;
  logic [NBYTES*8-1:0] staging_r;
  logic [NBYTES*8-1:0] word_s;
  logic [NBYTES*8-1:0] rx_data_r;
  logic                rx_valid_r;
  logic                rx_busy_r;
  logic                frame_err_r;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx.RxD),
    .q     (rxd_s)
  );

  // Completed word: earlier characters from staging, the final one straight from the shifter.
  always_comb begin
    word_s = staging_r;
    word_s[(NBYTES-1)*8 +: 8] = shift_r;
  end

  // Receive FSM with its counters, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tick_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      byte_cnt_r  <= '0;
      shift_r     <= 8'h00;
      staging_r   <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      rx_busy_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (rx.rx_en) begin
        case (state_r)
          IDLE: begin
            if (!rxd_s) begin
              state_r    <= START;
              tick_cnt_r <= '0;
              rx_busy_r  <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt_r == TICK_MID) begin
              tick_cnt_r <= '0;
              if (rxd_s) begin
                // Start bit did not survive to mid-bit: treat as line noise.
                state_r   <= IDLE;
                rx_busy_r <= 1'b0;
              end else begin
                state_r   <= DATA;
                bit_cnt_r <= 3'd0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r         <= '0;
              shift_r[bit_cnt_r] <= rxd_s;
              if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r <= 3'd0;
                state_r   <= STOP;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r <= '0;
              if (rxd_s) begin
                state_r   <= IDLE;
                rx_busy_r <= 1'b0;
                if (byte_cnt_r == BYTE_LAST) begin
                  rx_data_r  <= word_s;
                  rx_valid_r <= 1'b1;
                  byte_cnt_r <= '0;
                  staging_r  <= '0;
                end else begin
                  for (int k = 0; k < NBYTES; k++) begin
                    if (byte_cnt_r == BW'(k)) begin
                      staging_r[k*8 +: 8] <= shift_r;
                    end
                  end
                  byte_cnt_r <= byte_cnt_r + BW'(1);
                end
              end else begin
                // Bad stop bit drops the whole partial word; a break must clear before re-arming.
                frame_err_r <= 1'b1;
                byte_cnt_r  <= '0;
                staging_r   <= '0;
                state_r     <= WAIT_IDLE;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
          end
          WAIT_IDLE: begin
            if (rxd_s) begin
              state_r   <= IDLE;
              rx_busy_r <= 1'b0;
            end
          end
          default: begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            rx_busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.rx_data   = rx_data_r;
  assign rx.rx_valid  = rx_valid_r;
  assign rx.rx_busy   = rx_busy_r;
  assign rx.frame_err = frame_err_r;
endmodule
